// File: rtl/anc_output_mixer.sv
// ANC output mixer: ramps the anti-noise path in/out with a click-free coefficient,
// applies gain, sums with program audio and saturates to 16 bits (3-cycle latency).
module anc_output_mixer #(
    parameter int RAMP_STEP = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               audio_valid_in,
    input  logic signed [15:0] delayed_audio_in,
    input  logic signed [15:0] playback_in,
    input  logic               anc_enable_in,
    input  logic        [7:0]  gain_in,
    output logic signed [15:0] mix_out,
    output logic               mix_valid_out,
    output logic               clip_out,
    output logic               ramp_busy_out,
    output logic        [1:0]  state_dbg
);

    // Handshake: audio_valid_in is a one-cycle strobe with no back-pressure; every
    // strobe is accepted and produces exactly one mix_valid_out pulse three cycles later.

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [9:0] STEP_W = 10'(RAMP_STEP);
    localparam logic [8:0] STEP_N = 9'(RAMP_STEP);

    state_t      state, state_next;
    logic [8:0]  ramp, ramp_next;
    logic [9:0]  ramp_sum;
    logic [8:0]  ramp_inc, ramp_dec;

    // Stage registers
    logic               v1, v2;
    logic signed [24:0] a1;
    logic signed [15:0] pb1, pb2;
    logic        [8:0]  r1;
    logic signed [28:0] b_prod2;

    // Combinational datapath terms
    logic signed [24:0] d_ext, g_ext, a_prod;
    logic signed [28:0] a_wide, r_wide, b_prod;
    logic signed [28:0] pb_wide, b_shift, sum;
    logic signed [15:0] sat_val;
    logic               sat_clip;

    always_comb begin
        ramp_sum   = {1'b0, ramp} + STEP_W;
        ramp_inc   = (ramp_sum >= 10'd256) ? 9'd256 : ramp_sum[8:0];
        ramp_dec   = (ramp > STEP_N) ? (ramp - STEP_N) : 9'd0;
        state_next = state;
        ramp_next  = ramp;
        if (audio_valid_in) begin
            case (state)
                OFF: begin
                    ramp_next = 9'd0;
                    if (anc_enable_in) begin
                        state_next = RAMP_UP;
                        ramp_next  = ramp_inc;
                    end
                end
                RAMP_UP: begin
                    if (anc_enable_in) begin
                        ramp_next  = ramp_inc;
                        state_next = (ramp_inc == 9'd256) ? ON : RAMP_UP;
                    end else begin
                        ramp_next  = ramp_dec;
                        state_next = RAMP_DOWN;
                    end
                end
                ON: begin
                    ramp_next = 9'd256;
                    if (!anc_enable_in) begin
                        ramp_next  = ramp_dec;
                        state_next = (ramp_dec == 9'd0) ? OFF : RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (!anc_enable_in) begin
                        ramp_next  = ramp_dec;
                        state_next = (ramp_dec == 9'd0) ? OFF : RAMP_DOWN;
                    end else begin
                        ramp_next  = ramp_inc;
                        state_next = RAMP_UP;
                    end
                end
                default: begin
                    state_next = OFF;
                    ramp_next  = 9'd0;
                end
            endcase
        end
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        d_ext  = {{9{delayed_audio_in[15]}}, delayed_audio_in};
        g_ext  = {17'd0, gain_in};
        a_prod = d_ext * g_ext;
    end

    // Kept at 29 bits so neither shift truncates before the final clamp.
    always_comb begin
        a_wide = {{4{a1[24]}}, a1};
        r_wide = {20'd0, r1};
        b_prod = (a_wide >>> 6) * r_wide;
    end

    always_comb begin
        pb_wide  = {{13{pb2[15]}}, pb2};
        b_shift  = b_prod2 >>> 8;
        sum      = pb_wide + b_shift;
        sat_val  = sum[15:0];
        sat_clip = 1'b0;
        if (sum > 29'sd32767) begin
            sat_val  = 16'sh7fff;
            sat_clip = 1'b1;
        end else if (sum < -29'sd32768) begin
            sat_val  = 16'sh8000;
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= OFF;
            ramp  <= 9'd0;
            v1    <= 1'b0;
            a1    <= '0;
            pb1   <= '0;
            r1    <= '0;
        end else begin
            state <= state_next;
            ramp  <= ramp_next;
            v1    <= audio_valid_in;
            if (audio_valid_in) begin
                a1  <= a_prod;
                pb1 <= playback_in;
                r1  <= ramp;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v2      <= 1'b0;
            b_prod2 <= '0;
            pb2     <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                b_prod2 <= b_prod;
                pb2     <= pb1;
            end
        end
    end

    // Outputs hold their last value between strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mix_valid_out <= 1'b0;
            mix_out       <= '0;
            clip_out      <= 1'b0;
        end else begin
            mix_valid_out <= v2;
            if (v2) begin
                mix_out  <= sat_val;
                clip_out <= sat_clip;
            end
        end
    end

    assign ramp_busy_out = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign state_dbg     = state;

endmodule

// File: tb/tb_anc_output_mixer.sv
// Directed bench for anc_output_mixer (RAMP_STEP=64): bypass, ramp up/down/reverse,
// saturation, sampling gating, back-to-back strobes and asynchronous reset.
module tb_anc_output_mixer;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DOWN = 2'd3;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               audio_valid_in;
    logic signed [15:0] delayed_audio_in;
    logic signed [15:0] playback_in;
    logic               anc_enable_in;
    logic        [7:0]  gain_in;
    logic signed [15:0] mix_out;
    logic               mix_valid_out;
    logic               clip_out;
    logic               ramp_busy_out;
    logic        [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    anc_output_mixer #(.RAMP_STEP(64)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .audio_valid_in   (audio_valid_in),
        .delayed_audio_in (delayed_audio_in),
        .playback_in      (playback_in),
        .anc_enable_in    (anc_enable_in),
        .gain_in          (gain_in),
        .mix_out          (mix_out),
        .mix_valid_out    (mix_valid_out),
        .clip_out         (clip_out),
        .ramp_busy_out    (ramp_busy_out),
        .state_dbg        (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic strobe_now(input logic signed [15:0] d, input logic signed [15:0] pb,
                              input logic en, input logic [7:0] g);
        delayed_audio_in = d;
        playback_in      = pb;
        anc_enable_in    = en;
        gain_in          = g;
        audio_valid_in   = 1'b1;
    endtask

    task automatic finish_check(input logic signed [15:0] exp_mix, input logic exp_clip,
                                input string tag);
        @(negedge clk_in);
        audio_valid_in = 1'b0;
        chk({tag, ":lat1"}, {15'd0, mix_valid_out}, 16'd0);
        @(negedge clk_in);
        chk({tag, ":lat2"}, {15'd0, mix_valid_out}, 16'd0);
        @(negedge clk_in);
        chk({tag, ":valid"}, {15'd0, mix_valid_out}, 16'd1);
        chk({tag, ":mix"}, mix_out, exp_mix);
        chk({tag, ":clip"}, {15'd0, clip_out}, {15'd0, exp_clip});
    endtask

    task automatic send(input logic signed [15:0] d, input logic signed [15:0] pb,
                        input logic en, input logic [7:0] g,
                        input logic signed [15:0] exp_mix, input logic exp_clip,
                        input string tag);
        @(negedge clk_in);
        chk({tag, ":idle"}, {15'd0, mix_valid_out}, 16'd0);
        strobe_now(d, pb, en, g);
        finish_check(exp_mix, exp_clip, tag);
    endtask

    initial begin
        rst_in           = 1'b0;
        audio_valid_in   = 1'b0;
        delayed_audio_in = '0;
        playback_in      = '0;
        anc_enable_in    = 1'b0;
        gain_in          = '0;
        #3;
        chk("rst:mix",   mix_out, 16'd0);
        chk("rst:valid", {15'd0, mix_valid_out}, 16'd0);
        chk("rst:clip",  {15'd0, clip_out}, 16'd0);
        chk("rst:busy",  {15'd0, ramp_busy_out}, 16'd0);
        chk("rst:state", {14'd0, state_dbg}, {14'd0, S_OFF});
        @(negedge clk_in);
        rst_in = 1'b1;

        // Anti-noise off: playback passes through untouched.
        send(16'sd5000, 16'sd1000, 1'b0, 8'd64, 16'sd1000, 1'b0, "bypass");
        chk("bypass:state", {14'd0, state_dbg}, {14'd0, S_OFF});

        // Ramp up with step 64: R = 0, 64, 128, 192, 256.
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, 16'sd0, 1'b0, "up_r0");
        chk("up_r0:busy", {15'd0, ramp_busy_out}, 16'd1);
        chk("up_r0:state", {14'd0, state_dbg}, {14'd0, S_UP});
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd500, 1'b0, "up_r64");
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd1000, 1'b0, "up_r128");
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd1500, 1'b0, "up_r192");
        chk("up_r192:busy", {15'd0, ramp_busy_out}, 16'd0);
        chk("up_r192:state", {14'd0, state_dbg}, {14'd0, S_ON});
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd2000, 1'b0, "on_r256");
        repeat (3) @(negedge clk_in);
        chk("hold:mix", mix_out, -16'sd2000);
        chk("hold:valid", {15'd0, mix_valid_out}, 16'd0);

        // Saturation at both rails, then clip clears on a clean sample.
        send(16'sd30000, 16'sd30000, 1'b1, 8'd255, 16'sd32767, 1'b1, "clip_hi");
        send(-16'sd32768, -16'sd32768, 1'b1, 8'd255, -16'sd32768, 1'b1, "clip_lo");
        send(16'sd0, 16'sd0, 1'b1, 8'd255, 16'sd0, 1'b0, "clip_clr");

        // Enable/gain wiggles between strobes must be ignored.
        @(negedge clk_in);
        anc_enable_in = 1'b0;
        gain_in       = 8'd0;
        repeat (4) @(negedge clk_in);
        chk("gate:state", {14'd0, state_dbg}, {14'd0, S_ON});
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd2000, 1'b0, "gate");

        // Ramp down 256 -> 0, then reverse mid-ramp.
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, -16'sd2000, 1'b0, "dn_r256");
        chk("dn_r256:busy", {15'd0, ramp_busy_out}, 16'd1);
        chk("dn_r256:state", {14'd0, state_dbg}, {14'd0, S_DOWN});
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, -16'sd1500, 1'b0, "dn_r192");
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, -16'sd1000, 1'b0, "dn_r128");
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, -16'sd500, 1'b0, "dn_r64");
        chk("dn_r64:state", {14'd0, state_dbg}, {14'd0, S_OFF});
        chk("dn_r64:busy", {15'd0, ramp_busy_out}, 16'd0);
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, 16'sd0, 1'b0, "off_r0");
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, 16'sd0, 1'b0, "re_r0");
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd500, 1'b0, "re_r64");
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd1000, 1'b0, "re_r128");
        send(-16'sd2000, 16'sd0, 1'b0, 8'd64, -16'sd1500, 1'b0, "rev_r192");
        chk("rev_r192:state", {14'd0, state_dbg}, {14'd0, S_DOWN});
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd1000, 1'b0, "rev_r128");
        chk("rev_r128:state", {14'd0, state_dbg}, {14'd0, S_UP});
        send(-16'sd2000, 16'sd0, 1'b1, 8'd64, -16'sd1500, 1'b0, "rev_r192b");
        chk("rev_r192b:state", {14'd0, state_dbg}, {14'd0, S_ON});
        chk("rev_r192b:busy", {15'd0, ramp_busy_out}, 16'd0);

        // Eight back-to-back strobes while ON: mix = playback - 1.
        @(negedge clk_in);
        for (int i = 0; i < 12; i++) begin
            if (i >= 3 && i < 11) begin
                chk("burst:valid", {15'd0, mix_valid_out}, 16'd1);
                chk("burst:mix", mix_out, 16'(1000 * (i - 3) - 3001));
            end else begin
                chk("burst:gap", {15'd0, mix_valid_out}, 16'd0);
            end
            if (i < 8) strobe_now(-16'sd1, 16'(1000 * i - 3000), 1'b1, 8'd64);
            else audio_valid_in = 1'b0;
            @(negedge clk_in);
        end

        // Reset one cycle after a strobe discards it.
        strobe_now(16'sd0, 16'sd1234, 1'b0, 8'd64);
        @(negedge clk_in);
        audio_valid_in = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk("arst:mix",   mix_out, 16'd0);
        chk("arst:valid", {15'd0, mix_valid_out}, 16'd0);
        chk("arst:clip",  {15'd0, clip_out}, 16'd0);
        chk("arst:busy",  {15'd0, ramp_busy_out}, 16'd0);
        chk("arst:state", {14'd0, state_dbg}, {14'd0, S_OFF});
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) begin
            @(negedge clk_in);
            chk("arst:drop", {15'd0, mix_valid_out}, 16'd0);
        end
        send(16'sd0, 16'sd777, 1'b0, 8'd64, 16'sd777, 1'b0, "post_rst");

        // A strobe presented right at reset release is taken on the first edge.
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        strobe_now(16'sd0, -16'sd555, 1'b0, 8'd64);
        finish_check(-16'sd555, 1'b0, "first_edge");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
